unit_nxm: RTL and testbench
===========================

UNIT_NXM -- requirements
Module: unit_nxm

Interface
REQ-001 SHALL have parameter N_IN, default 3, meaning fan-in (number of forward inputs, >=1).
REQ-002 SHALL have parameter N_OUT, default 3, meaning fan-out (number of forward outputs, >=1).
REQ-003 SHALL have parameter W_INIT, width N_IN*N_OUT, default all-zero, meaning weight reset image; bit k = j*N_IN+i is weight w[j][i], where 1 = +1 and 0 = -1.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port oscillator, input, 1 bit: stochastic bit, used for tie-break and update gating.
REQ-007 SHALL have port fd_prop, input, 1 bit: forward-pass request.
REQ-008 SHALL have port bk_prop, input, 1 bit: backward-pass request.
REQ-009 SHALL have port scan_start, input, 1 bit: weight readout request.
REQ-010 SHALL have port fin, input, N_IN bits: forward activations.
REQ-011 SHALL have port bin, input, N_OUT bits: backward error signs.
REQ-012 SHALL have port fout, output, N_OUT bits: forward results, registered.
REQ-013 SHALL have port bout, output, N_IN bits: backward results, registered.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a forward or backward pass.
REQ-016 SHALL have port control_out, output, 1 bit: serial weight bit.
REQ-017 SHALL have port control_valid, output, 1 bit: control_out qualifier.

Function
REQ-018 SHALL implement the FSM states IDLE, FWD, BWD and SCAN; requests are sampled only in IDLE; requests arriving while busy are dropped.
REQ-019 SHALL resolve simultaneous requests in IDLE with priority fd_prop > bk_prop > scan_start; losing requests are dropped.
REQ-020 SHALL, on accepting fd_prop at cycle t, latch fin into fin_q and step j = 0..N_OUT-1 in cycles t+1..t+N_OUT; the vote for j is c = popcount(fin_q XNOR w[j][*]).
REQ-021 SHALL set fout[j] = 1 if 2c > N_IN, 0 if 2c < N_IN, and oscillator (sampled in the cycle j is evaluated) if 2c == N_IN.
REQ-022 SHALL update all fout bits together and pulse done at cycle t+N_OUT+1, then return to IDLE; fout holds its value otherwise.
REQ-023 SHALL, on accepting bk_prop, latch bin into bin_q and step i = 0..N_IN-1 (N_IN cycles); the vote for i is over j of bin_q[j] XNOR w[j][i], with the same majority/tie rule against N_OUT; bout and done follow at cycle t+N_IN+1.
REQ-024 SHALL, on accepting scan_start, drive control_out = bit k of the weight image for k = 0..N_IN*N_OUT-1 on consecutive cycles with control_valid high, then return to IDLE; control_out is 0 whenever control_valid is low.
REQ-025 SHALL size the step counters as $clog2 of max(N_IN, N_OUT, N_IN*N_OUT) with a minimum of 1 bit; the counter clears on each state entry and never wraps inside a pass.
REQ-026 SHALL retain fin_q between passes; a bk_prop with no prior forward pass uses fin_q = 0.

Reset
REQ-027 SHALL, on rst_in high at any clock edge, including mid-pass, force state IDLE, weights to W_INIT, fin_q, bin_q, fout and bout to 0, and done, busy, control_out and control_valid to 0; an interrupted pass produces no done.

Configuration
REQ-028 SHALL, with UNIT_WEIGHT_UPDATE_EN defined, in BWD step i and for every j, write w[j][i] <= fin_q[i] XNOR bin_q[j] when oscillator is 1 in that cycle; the vote for step i uses the pre-write weights.
REQ-029 SHALL, without UNIT_WEIGHT_UPDATE_EN, hold weights at W_INIT permanently; bout is still computed.

Structure
REQ-030 SHALL place the state enum and the counter-width helper function in the shared package unit_pkg.
REQ-031 SHALL use one sub-module, unit_vote (parametrised width: XNOR, popcount, majority with oscillator tie-break), instantiated once and time-shared between FWD and BWD.

Verification
REQ-032 SHALL cover: N_IN=N_OUT=3, W_INIT all-ones, fin=011, fd_prop -> fout=111 and done exactly 4 cycles after acceptance; fin=000 -> fout=000.
REQ-033 SHALL cover: N_IN=2, W_INIT all-ones, fin=01 (tie) -> with oscillator held 1, fout all-ones; with oscillator held 0, fout all-zero.
REQ-034 SHALL cover: W_INIT=9'b100000001, scan_start -> control_out sequence 1,0,0,0,0,0,0,0,1 with control_valid high for exactly 9 cycles.
REQ-035 SHALL cover, with the macro defined: W_INIT=0, fd fin=101, then bk bin=111 with oscillator held 1 -> a subsequent scan yields 1,0,1,1,0,1,1,0,1; without the macro, the same scan yields all zeros.
REQ-036 SHALL cover: fd_prop and bk_prop asserted together -> only FWD runs; rst_in during cycle 2 of FWD -> busy=0 next cycle, no done, fout=0.

Source files
------------

// File: rtl/unit_pkg.sv
// unit_pkg: shared FSM state type and sizing helpers for the unit_nxm binary-weight layer.
package unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_BWD,
        ST_SCAN
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Step counter width; the scan pass is the longest, so it sets the bound.
    function automatic int unsigned cnt_width(input int unsigned n_in, input int unsigned n_out);
        int unsigned w;
        w = $clog2(max3(n_in, n_out, n_in * n_out));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/unit_nxm_if.sv
// unit_nxm_if: bundles the request/response pins of one unit_nxm instance.
interface unit_nxm_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 3
);
    logic              oscillator;
    logic              fd_prop;
    logic              bk_prop;
    logic              scan_start;
    logic [N_IN-1:0]   fin;
    logic [N_OUT-1:0]  bin;
    logic [N_OUT-1:0]  fout;
    logic [N_IN-1:0]   bout;
    logic              busy;
    logic              done;
    logic              control_out;
    logic              control_valid;

    modport master (
        output oscillator, fd_prop, bk_prop, scan_start, fin, bin,
        input  fout, bout, busy, done, control_out, control_valid
    );

    modport slave (
        input  oscillator, fd_prop, bk_prop, scan_start, fin, bin,
        output fout, bout, busy, done, control_out, control_valid
    );
endinterface

// File: rtl/unit_vote.sv
// unit_vote: masked XNOR popcount compared against half of n_i; an exact tie takes osc_i.
module unit_vote #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0]             a_i,
    input  logic [W-1:0]             b_i,
    input  logic [W-1:0]             mask_i,
    input  logic [$clog2(W+1)-1:0]   n_i,
    input  logic                     osc_i,
    output logic                     vote_o
);
    localparam int unsigned NW = $clog2(W + 1);

    logic [NW-1:0] cnt;
    logic [NW:0]   twice;
    logic [NW:0]   n_ext;

    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < W; k++) begin
            if (mask_i[k] && (a_i[k] == b_i[k])) cnt = cnt + NW'(1);
        end
        twice = {cnt, 1'b0};
        n_ext = {1'b0, n_i};
        if (twice > n_ext)      vote_o = 1'b1;
        else if (twice < n_ext) vote_o = 1'b0;
        else                    vote_o = osc_i;
    end
endmodule

// File: rtl/unit_nxm.sv
// unit_nxm: binary-weight N_IN x N_OUT layer; serial forward/backward majority votes and weight scan.
// Define UNIT_WEIGHT_UPDATE_EN to enable oscillator-gated weight learning during backward passes.
module unit_nxm
    import unit_pkg::*;
#(
    parameter int unsigned           N_IN   = 3,
    parameter int unsigned           N_OUT  = 3,
    parameter logic [N_IN*N_OUT-1:0] W_INIT = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              oscillator,
    input  logic              fd_prop,
    input  logic              bk_prop,
    input  logic              scan_start,
    input  logic [N_IN-1:0]   fin,
    input  logic [N_OUT-1:0]  bin,
    output logic [N_OUT-1:0]  fout,
    output logic [N_IN-1:0]   bout,
    output logic              busy,
    output logic              done,
    output logic              control_out,
    output logic              control_valid
);
    localparam int unsigned NW  = N_IN * N_OUT;
    localparam int unsigned CW  = cnt_width(N_IN, N_OUT);
    localparam int unsigned VW  = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int unsigned VNW = $clog2(VW + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   fin_q, fin_d;
    logic [N_OUT-1:0]  bin_q, bin_d;
    logic [N_OUT-1:0]  facc_q, facc_d;
    logic [N_IN-1:0]   bacc_q, bacc_d;
    logic [N_OUT-1:0]  fout_q, fout_d;
    logic [N_IN-1:0]   bout_q, bout_d;
    logic              done_q, done_d;
    logic [NW-1:0]     w_q, w_d;

    logic [VW-1:0]     va, vb, vmask;
    logic [VNW-1:0]    vn;
    logic              vote;
    logic              scan_bit;

    // One voter serves both directions: FWD compares fin_q with row j, BWD compares bin_q with column i.
    always_comb begin
        va       = '0;
        vb       = '0;
        vmask    = '0;
        vn       = '0;
        scan_bit = 1'b0;
        case (state_q)
            ST_FWD: begin
                vn = VNW'(N_IN);
                for (int unsigned i = 0; i < N_IN; i++) begin
                    va[i]    = fin_q[i];
                    vmask[i] = 1'b1;
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        if (cnt_q == CW'(j)) vb[i] = w_q[j*N_IN+i];
                    end
                end
            end
            ST_BWD: begin
                vn = VNW'(N_OUT);
                for (int unsigned j = 0; j < N_OUT; j++) begin
                    va[j]    = bin_q[j];
                    vmask[j] = 1'b1;
                    for (int unsigned i = 0; i < N_IN; i++) begin
                        if (cnt_q == CW'(i)) vb[j] = w_q[j*N_IN+i];
                    end
                end
            end
            ST_SCAN: begin
                for (int unsigned k = 0; k < NW; k++) begin
                    if (cnt_q == CW'(k)) scan_bit = w_q[k];
                end
            end
            default: ;
        endcase
    end

    unit_vote #(.W(VW)) u_vote (
        .a_i    (va),
        .b_i    (vb),
        .mask_i (vmask),
        .n_i    (vn),
        .osc_i  (oscillator),
        .vote_o (vote)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        bin_d   = bin_q;
        facc_d  = facc_q;
        bacc_d  = bacc_q;
        fout_d  = fout_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        w_d     = w_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fd_prop) begin
                    fin_d   = fin;
                    state_d = ST_FWD;
                end else if (bk_prop) begin
                    bin_d   = bin;
                    state_d = ST_BWD;
                end else if (scan_start) begin
                    state_d = ST_SCAN;
                end
            end
            ST_FWD: begin
                for (int unsigned j = 0; j < N_OUT; j++) begin
                    if (cnt_q == CW'(j)) facc_d[j] = vote;
                end
                if (cnt_q == CW'(N_OUT - 1)) begin
                    fout_d  = facc_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BWD: begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if (cnt_q == CW'(i)) bacc_d[i] = vote;
                end
`ifdef UNIT_WEIGHT_UPDATE_EN
                // Only column i is written at step i, so later votes still see their pre-write column.
                if (oscillator) begin
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        for (int unsigned i = 0; i < N_IN; i++) begin
                            if (cnt_q == CW'(i)) w_d[j*N_IN+i] = ~(fin_q[i] ^ bin_q[j]);
                        end
                    end
                end
`endif
                if (cnt_q == CW'(N_IN - 1)) begin
                    bout_d  = bacc_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SCAN: begin
                if (cnt_q == CW'(NW - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fin_q   <= '0;
            bin_q   <= '0;
            facc_q  <= '0;
            bacc_q  <= '0;
            fout_q  <= '0;
            bout_q  <= '0;
            done_q  <= 1'b0;
            w_q     <= W_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            bin_q   <= bin_d;
            facc_q  <= facc_d;
            bacc_q  <= bacc_d;
            fout_q  <= fout_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            w_q     <= w_d;
        end
    end

    assign fout          = fout_q;
    assign bout          = bout_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);
    assign control_valid = (state_q == ST_SCAN);
    assign control_out   = control_valid & scan_bit;

endmodule

// File: tb/tb_unit_nxm.sv
// tb_unit_nxm: four unit_nxm configurations driven in lockstep, checked by a queue scoreboard against a behavioural model.
module tb_unit_nxm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       osc = 1'b0, fd = 1'b0, bk = 1'b0, sc = 1'b0;
    logic [2:0] fin_s = '0, bin_s = '0;
    int         cyc = 0;
    bit         started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    unit_nxm_if #(.N_IN(3), .N_OUT(3)) if_a ();
    unit_nxm_if #(.N_IN(2), .N_OUT(3)) if_b ();
    unit_nxm_if #(.N_IN(3), .N_OUT(3)) if_c ();
    unit_nxm_if #(.N_IN(3), .N_OUT(3)) if_d ();

    assign if_a.oscillator = osc; assign if_a.fd_prop = fd; assign if_a.bk_prop = bk;
    assign if_a.scan_start = sc;  assign if_a.fin = fin_s;   assign if_a.bin = bin_s;
    assign if_b.oscillator = osc; assign if_b.fd_prop = fd; assign if_b.bk_prop = bk;
    assign if_b.scan_start = sc;  assign if_b.fin = fin_s[1:0]; assign if_b.bin = bin_s;
    assign if_c.oscillator = osc; assign if_c.fd_prop = fd; assign if_c.bk_prop = bk;
    assign if_c.scan_start = sc;  assign if_c.fin = fin_s;   assign if_c.bin = bin_s;
    assign if_d.oscillator = osc; assign if_d.fd_prop = fd; assign if_d.bk_prop = bk;
    assign if_d.scan_start = sc;  assign if_d.fin = fin_s;   assign if_d.bin = bin_s;

    unit_nxm #(.N_IN(3), .N_OUT(3), .W_INIT(9'h1FF)) dut_a (
        .clk_in(clk), .rst_in(rst), .oscillator(if_a.oscillator), .fd_prop(if_a.fd_prop),
        .bk_prop(if_a.bk_prop), .scan_start(if_a.scan_start), .fin(if_a.fin), .bin(if_a.bin),
        .fout(if_a.fout), .bout(if_a.bout), .busy(if_a.busy), .done(if_a.done),
        .control_out(if_a.control_out), .control_valid(if_a.control_valid));
    unit_nxm #(.N_IN(2), .N_OUT(3), .W_INIT(6'h3F)) dut_b (
        .clk_in(clk), .rst_in(rst), .oscillator(if_b.oscillator), .fd_prop(if_b.fd_prop),
        .bk_prop(if_b.bk_prop), .scan_start(if_b.scan_start), .fin(if_b.fin), .bin(if_b.bin),
        .fout(if_b.fout), .bout(if_b.bout), .busy(if_b.busy), .done(if_b.done),
        .control_out(if_b.control_out), .control_valid(if_b.control_valid));
    unit_nxm #(.N_IN(3), .N_OUT(3), .W_INIT(9'b100000001)) dut_c (
        .clk_in(clk), .rst_in(rst), .oscillator(if_c.oscillator), .fd_prop(if_c.fd_prop),
        .bk_prop(if_c.bk_prop), .scan_start(if_c.scan_start), .fin(if_c.fin), .bin(if_c.bin),
        .fout(if_c.fout), .bout(if_c.bout), .busy(if_c.busy), .done(if_c.done),
        .control_out(if_c.control_out), .control_valid(if_c.control_valid));
    unit_nxm #(.N_IN(3), .N_OUT(3), .W_INIT(9'h000)) dut_d (
        .clk_in(clk), .rst_in(rst), .oscillator(if_d.oscillator), .fd_prop(if_d.fd_prop),
        .bk_prop(if_d.bk_prop), .scan_start(if_d.scan_start), .fin(if_d.fin), .bin(if_d.bin),
        .fout(if_d.fout), .bout(if_d.bout), .busy(if_d.busy), .done(if_d.done),
        .control_out(if_d.control_out), .control_valid(if_d.control_valid));

    logic [3:0] done_v, busy_v, cv_v, co_v;
    logic [2:0] fout_v [4];
    logic [2:0] bout_v [4];
    assign done_v = {if_d.done, if_c.done, if_b.done, if_a.done};
    assign busy_v = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
    assign cv_v   = {if_d.control_valid, if_c.control_valid, if_b.control_valid, if_a.control_valid};
    assign co_v   = {if_d.control_out, if_c.control_out, if_b.control_out, if_a.control_out};
    assign fout_v[0] = if_a.fout; assign fout_v[1] = if_b.fout;
    assign fout_v[2] = if_c.fout; assign fout_v[3] = if_d.fout;
    assign bout_v[0] = if_a.bout; assign bout_v[1] = {1'b0, if_b.bout};
    assign bout_v[2] = if_c.bout; assign bout_v[3] = if_d.bout;

    // Reference model: per-configuration weight image (bit j*N_IN+i = w[j][i]) and latched operands.
    localparam int NIN [4] = '{3, 2, 3, 3};
    localparam int NOUT = 3;
    logic [8:0] WI [4];
    initial begin
        WI[0] = 9'h1FF; WI[1] = 9'h03F; WI[2] = 9'b100000001; WI[3] = 9'h000;
    end
    logic [8:0] mw   [4];
    logic [2:0] mfin [4];

    typedef struct { int cyc; bit bwd; logic [2:0] val; } exp_t;
    typedef struct { int cyc; logic b; } sexp_t;
    exp_t  dq [4][$];
    sexp_t sq [4][$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d actual=%0h required=%0h at cycle %0d", name, d, act, req, cyc);
    endtask

    function automatic logic maj(input int c, input int n, input logic o);
        if (2 * c > n) return 1'b1;
        if (2 * c < n) return 1'b0;
        return o;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 4; d++) begin
            mw[d]   = WI[d];
            mfin[d] = '0;
        end
    endtask

    task automatic m_fwd(input logic [2:0] f, input logic [2:0] o, input int c0);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            int   cnt;
            mfin[d] = '0;
            for (int i = 0; i < NIN[d]; i++) mfin[d][i] = f[i];
            e.cyc = c0 + NOUT + 1;
            e.bwd = 1'b0;
            e.val = '0;
            for (int j = 0; j < NOUT; j++) begin
                cnt = 0;
                for (int i = 0; i < NIN[d]; i++) if (f[i] == mw[d][j*NIN[d]+i]) cnt++;
                e.val[j] = maj(cnt, NIN[d], o[j]);
            end
            dq[d].push_back(e);
        end
    endtask

    task automatic m_bwd(input logic [2:0] b, input logic [2:0] o, input int c0);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            int   cnt;
            e.cyc = c0 + NIN[d] + 1;
            e.bwd = 1'b1;
            e.val = '0;
            for (int i = 0; i < NIN[d]; i++) begin
                cnt = 0;
                for (int j = 0; j < NOUT; j++) if (b[j] == mw[d][j*NIN[d]+i]) cnt++;
                e.val[i] = maj(cnt, NOUT, o[i]);
            end
`ifdef UNIT_WEIGHT_UPDATE_EN
            for (int i = 0; i < NIN[d]; i++)
                if (o[i])
                    for (int j = 0; j < NOUT; j++) mw[d][j*NIN[d]+i] = (mfin[d][i] == b[j]);
`endif
            dq[d].push_back(e);
        end
    endtask

    task automatic m_scan(input int c0);
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < NIN[d] * NOUT; k++) begin
                sexp_t s;
                s.cyc = c0 + 1 + k;
                s.b   = mw[d][k];
                sq[d].push_back(s);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents done or a valid scan bit.
    always @(negedge clk) begin
        if (started && !rst) begin
            for (int d = 0; d < 4; d++) begin
                if (done_v[d]) begin
                    if (dq[d].size() == 0) begin
                        check("unexpected_done", d, 32'(done_v[d]), 32'd0);
                    end else begin
                        exp_t e;
                        e = dq[d].pop_front();
                        check("done_cycle", d, cyc, e.cyc);
                        if (e.bwd) check("bout", d, 32'(bout_v[d]), 32'(e.val));
                        else       check("fout", d, 32'(fout_v[d]), 32'(e.val));
                    end
                end
                if (cv_v[d]) begin
                    if (sq[d].size() == 0) begin
                        check("unexpected_scan", d, 32'(cv_v[d]), 32'd0);
                    end else begin
                        sexp_t s;
                        s = sq[d].pop_front();
                        check("scan_cycle", d, cyc, s.cyc);
                        check("scan_bit", d, 32'(co_v[d]), 32'(s.b));
                    end
                end else begin
                    check("control_out_idle", d, 32'(co_v[d]), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 4; d++) begin
            check({tag, "_busy"}, d, 32'(busy_v[d]), 32'd0);
            check({tag, "_fout"}, d, 32'(fout_v[d]), 32'd0);
            check({tag, "_bout"}, d, 32'(bout_v[d]), 32'd0);
            check({tag, "_done"}, d, 32'(done_v[d]), 32'd0);
        end
    endtask

    // op: 0 fwd, 1 bwd, 2 scan, 3 fd+bk, 4 fd+bk+scan; intr pulses {sc,bk,fd} once while busy.
    task automatic do_pass(input int op, input logic [2:0] f, input logic [2:0] b,
                           input logic [2:0] o, input logic [2:0] intr);
        int steps;
        fin_s = f;
        bin_s = b;
        fd = (op == 0 || op == 3 || op == 4);
        bk = (op == 1 || op == 3 || op == 4);
        sc = (op == 2 || op == 4);
        case (op)
            1:       m_bwd(b, o, cyc);
            2:       m_scan(cyc);
            default: m_fwd(f, o, cyc);
        endcase
        steps = (op == 2) ? 11 : 5;
        tick();
        fd = 1'b0; bk = 1'b0; sc = 1'b0;
        for (int d = 0; d < 4; d++) check("busy_after_accept", d, 32'(busy_v[d]), 32'd1);
        for (int s = 0; s < steps; s++) begin
            osc = (s < 3) ? o[s] : 1'($urandom);
            if (s == 1 && intr != 3'b000) begin
                fd = intr[0]; bk = intr[1]; sc = intr[2];
                fin_s = 3'($urandom); bin_s = 3'($urandom);
            end else begin
                fd = 1'b0; bk = 1'b0; sc = 1'b0;
            end
            tick();
        end
        for (int d = 0; d < 4; d++) check("busy_idle", d, 32'(busy_v[d]), 32'd0);
    endtask

    task automatic mid_reset(input logic [2:0] f);
        fin_s = f;
        fd    = 1'b1;
        tick();
        fd  = 1'b0;
        osc = 1'($urandom);
        tick();
        rst = 1'b1;
        tick();
        check_cleared("midrst");
        rst = 1'b0;
        m_reset();
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_cleared("reset");
        started = 1'b1;
        tick();

        do_pass(0, 3'b011, 3'b000, 3'b000, 3'b000);
        do_pass(0, 3'b000, 3'b000, 3'b111, 3'b000);
        do_pass(0, 3'b001, 3'b000, 3'b111, 3'b000);
        do_pass(0, 3'b001, 3'b000, 3'b000, 3'b000);
        do_pass(2, 3'b000, 3'b000, 3'b000, 3'b000);
        do_pass(3, 3'b110, 3'b101, 3'b010, 3'b000);
        mid_reset(3'b111);

        do_pass(0, 3'b101, 3'b000, 3'b000, 3'b000);
        do_pass(1, 3'b000, 3'b111, 3'b111, 3'b000);
        do_pass(2, 3'b000, 3'b000, 3'b000, 3'b000);

        for (int n = 0; n < 40; n++) begin
            int         op;
            logic [2:0] f, b, o, intr;
            op   = $urandom_range(0, 5);
            f    = 3'($urandom);
            b    = 3'($urandom);
            o    = 3'($urandom);
            intr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (op == 5) mid_reset(f);
            else         do_pass(op, f, b, o, intr);
        end

        repeat (4) tick();
        for (int d = 0; d < 4; d++) begin
            check("pending_done", d, dq[d].size(), 0);
            check("pending_scan", d, sq[d].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
